// File: rtl/roi_frame_sequencer.sv
// roi_frame_sequencer
// Sequences one camera frame through a Hough stage. During ingest the full
// WIDTH x HEIGHT raster is cropped to the region of interest and only ROI
// pixels go to the image FIFO. After hough_done it rebuilds a full frame:
// ROI positions take highlight bytes and every other position gets FILL_PIXEL.
//
// Ports
//   clock, reset             single clock, synchronous active-high reset
//   in_dout/in_empty         upstream FWFT pixel FIFO head and empty flag
//   in_rd_en                 pop upstream FIFO
//   image_din/image_wr_en    ROI pixel write into Hough image FIFO
//   image_full               image FIFO full
//   hough_done               level, highlight stream is available
//   highlight_dout/_empty    highlight FWFT FIFO head byte and empty flag
//   highlight_rd_en          pop highlight FIFO
//   out_din/out_wr_en        output frame word and write strobe
//   out_full                 output FIFO full
//   state_out                0=INGEST 1=WAIT 2=EMIT 3=DONE
//   frame_done               one-cycle pulse after the last output word
module roi_frame_sequencer #(
  parameter int unsigned WIDTH      = 1280,
  parameter int unsigned HEIGHT     = 720,
  parameter int unsigned ROI_X0     = 0,
  parameter int unsigned ROI_Y0     = 0,
  parameter int unsigned ROI_W      = 568,
  parameter int unsigned ROI_H      = 320,
  parameter logic [23:0] FILL_PIXEL = 24'h00FF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] in_dout,
  input  logic        in_empty,
  output logic        in_rd_en,
  output logic [23:0] image_din,
  output logic        image_wr_en,
  input  logic        image_full,
  input  logic        hough_done,
  input  logic [7:0]  highlight_dout,
  input  logic        highlight_empty,
  output logic        highlight_rd_en,
  output logic [23:0] out_din,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic [1:0]  state_out,
  output logic        frame_done
);

  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);
  localparam int unsigned XC = XW + 1;
  localparam int unsigned YC = YW + 1;

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [XC-1:0] X0_C   = XC'(ROI_X0);
  localparam logic [YC-1:0] Y0_C   = YC'(ROI_Y0);
  localparam logic [XC-1:0] RW_C   = XC'(ROI_W);
  localparam logic [YC-1:0] RH_C   = YC'(ROI_H);

  typedef enum logic [1:0] {
    S_INGEST = 2'd0,
    S_WAIT   = 2'd1,
    S_EMIT   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [XC-1:0] x_off_s;
  logic [YC-1:0] y_off_s;
  logic          in_roi_s;
  logic          advance_s;

  // ROI test as one unsigned range check per axis: with one extra bit of
  // headroom, a coordinate left of / above the ROI wraps to a value far
  // larger than the ROI extent, so no separate lower-bound compare is needed.
  assign x_off_s  = {1'b0, x_q} - X0_C;
  assign y_off_s  = {1'b0, y_q} - Y0_C;
  assign in_roi_s = (x_off_s < RW_C) && (y_off_s < RH_C);

  // Next-state, counter and strobe logic.
  always_comb begin
    state_d         = state_q;
    x_d             = x_q;
    y_d             = y_q;
    advance_s       = 1'b0;
    in_rd_en        = 1'b0;
    image_wr_en     = 1'b0;
    image_din       = 24'h000000;
    highlight_rd_en = 1'b0;
    out_wr_en       = 1'b0;
    out_din         = 24'h000000;
    frame_done      = 1'b0;
    state_out       = 2'd0;

    case (state_q)
      S_INGEST: begin
        if (in_roi_s) begin
          if (!in_empty && !image_full) begin
            in_rd_en    = 1'b1;
            image_wr_en = 1'b1;
            image_din   = in_dout;
            advance_s   = 1'b1;
          end else begin
            advance_s   = 1'b0;
          end
        end else begin
          // Outside the ROI the pixel is dropped, so image_full is irrelevant.
          if (!in_empty) begin
            in_rd_en  = 1'b1;
            advance_s = 1'b1;
          end else begin
            advance_s = 1'b0;
          end
        end
      end
      S_WAIT: begin
        if (hough_done) begin
          state_d = S_EMIT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_EMIT: begin
        if (out_full) begin
          advance_s = 1'b0;
        end else if (in_roi_s) begin
          if (!highlight_empty) begin
            highlight_rd_en = 1'b1;
            out_wr_en       = 1'b1;
            out_din         = {highlight_dout, 8'h00, 8'h00};
            advance_s       = 1'b1;
          end else begin
            advance_s       = 1'b0;
          end
        end else begin
          out_wr_en = 1'b1;
          out_din   = FILL_PIXEL;
          advance_s = 1'b1;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_INGEST;
      end
      default: begin
        state_d = S_INGEST;
      end
    endcase

    // Raster advance; the last pixel of a pass wraps the counters and ends
    // the pass (ingest hands over to WAIT, emit to DONE).
    if (advance_s) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d     = '0;
          state_d = (state_q == S_INGEST) ? S_WAIT : S_DONE;
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end else begin
      x_d = x_q;
    end

    // Reset silences every output in the reset cycle itself, not just after it.
    if (reset) begin
      state_d         = S_INGEST;
      x_d             = '0;
      y_d             = '0;
      in_rd_en        = 1'b0;
      image_wr_en     = 1'b0;
      image_din       = 24'h000000;
      highlight_rd_en = 1'b0;
      out_wr_en       = 1'b0;
      out_din         = 24'h000000;
      frame_done      = 1'b0;
      state_out       = 2'd0;
    end else begin
      state_out       = state_q;
    end
  end

  // State and raster counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_INGEST;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

endmodule

// File: doc/roi_frame_sequencer.md
# roi_frame_sequencer

Controller that wraps `hough_top` and sequences one full camera frame through it. During ingest it crops a full WIDTH×HEIGHT pixel stream down to a rectangular region of interest (ROI) and writes only ROI pixels into the Hough image FIFO. It then waits for `hough_done`. During emit it rebuilds a full-size output frame: ROI positions take the highlight bytes and every other position gets a fill colour. It sits between the upstream pixel FIFO and the downstream frame-writer FIFO.

## Interface
- WIDTH, 1280, full frame width in pixels
- HEIGHT, 720, full frame height in pixels
- ROI_X0, 0, first ROI column
- ROI_Y0, 0, first ROI row
- ROI_W, 568, ROI width; ROI_X0+ROI_W ≤ WIDTH
- ROI_H, 320, ROI height; ROI_Y0+ROI_H ≤ HEIGHT
- FILL_PIXEL, 24'h00FF00, word emitted outside the ROI
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_dout  in  24  upstream FWFT FIFO head pixel, bits [7:0] first byte in BMP order
- in_empty  in  1  upstream FIFO empty
- in_rd_en  out  1  pop upstream FIFO
- image_din  out  24  pixel to `hough_top` image FIFO
- image_wr_en  out  1  write strobe to image FIFO
- image_full  in  1  image FIFO full
- hough_done  in  1  level; Hough lane outputs valid and highlight stream available
- highlight_dout  in  8  highlight FWFT FIFO head byte
- highlight_empty  in  1  highlight FIFO empty
- highlight_rd_en  out  1  pop highlight FIFO
- out_din  out  24  output frame word
- out_wr_en  out  1  write strobe to output FIFO
- out_full  in  1  output FIFO full
- state_out  out  2  0=INGEST, 1=WAIT, 2=EMIT, 3=DONE
- frame_done  out  1  one-cycle pulse when a full output frame has been written

## Operation
- Counters: x is $clog2(WIDTH) bits, y is $clog2(HEIGHT) bits. Raster order, x fastest. When x=WIDTH-1 on advance: x←0, y←y+1.
- in_roi = (x ≥ ROI_X0) && (x < ROI_X0+ROI_W) && (y ≥ ROI_Y0) && (y < ROI_Y0+ROI_H).
- INGEST, when in_roi and !in_empty and !image_full:
  - in_rd_en=1, image_wr_en=1, image_din=in_dout.
  - Advance counters.
- INGEST, when !in_roi and !in_empty:
  - in_rd_en=1, pixel discarded, advance counters.
  - image_full is ignored for discarded pixels.
- INGEST, otherwise: all strobes 0, counters hold.
- Consuming pixel (WIDTH-1, HEIGHT-1) → WAIT; x,y ← 0.
- WAIT: all strobes 0. When hough_done=1 → EMIT on the next edge.
- EMIT, when out_full=1: all strobes 0, counters hold.
- EMIT, when in_roi and !highlight_empty (and !out_full):
  - highlight_rd_en=1, out_wr_en=1, out_din={highlight_dout, 8'h00, 8'h00}.
  - Advance counters.
- EMIT, when in_roi and highlight_empty: all strobes 0, counters hold.
- EMIT, when !in_roi (and !out_full): out_wr_en=1, out_din=FILL_PIXEL, advance counters.
- Writing pixel (WIDTH-1, HEIGHT-1) → DONE; x,y ← 0.
- DONE: frame_done=1 for one cycle, all other strobes 0, then → INGEST.

## Timing
- All strobes and data outputs (in_rd_en, image_wr_en, image_din, highlight_rd_en, out_wr_en, out_din) are combinational from the registered state, counters and the current-cycle FIFO flags. Pop and write happen on the same edge.
- State and counters are registered.
- Throughput: 1 pixel/cycle in INGEST and EMIT when unstalled.
- Minimum frame time: 2·WIDTH·HEIGHT + 2 cycles plus the Hough wait. WAIT→EMIT takes 1 cycle after hough_done is seen.
- Reset (any state, including mid-frame):
  - Next state is INGEST; x=y=0.
  - All strobes, image_din, out_din, frame_done are 0 during and after the reset cycle until the first qualifying handshake.
  - state_out=0.
- hough_done asserted during INGEST is ignored; it is only sampled in WAIT.
- If in_empty and image_full are both high at an ROI pixel: stall, no pop.
- If out_full and highlight_empty are both high: stall, no pop.
- A frame_done pulse is never asserted in the same cycle as any strobe.

## Test plan
Bench parameters for all scenarios: WIDTH=8, HEIGHT=4, ROI_X0=2, ROI_Y0=1, ROI_W=3, ROI_H=2. Raster index = y·8 + x.
- Reset: hold reset for 3 cycles with in_empty=0 → in_rd_en=0, image_wr_en=0, out_wr_en=0, state_out=0 throughout. First pop occurs in the cycle after reset falls.
- Ingest crop: feed pixels whose value equals raster index 0..31, in_empty=0, image_full=0 → exactly 32 pops in 32 cycles. Exactly 6 image writes, with values 10, 11, 12, 18, 19, 20. state_out=1 after the 32nd pop.
- Backpressure: image_full=1 from index 8 to 15 → indices 8 and 9 drain without writes. Counter stalls at index 10 with in_rd_en=0 until image_full drops. Write order is unchanged.
- Emit: enter WAIT, assert hough_done, highlight FIFO holds 6 bytes A1..A6 → 32 out writes. Indices 10–12 and 18–20 carry {Ak, 00, 00}. The other 26 indices carry 24'h00FF00. frame_done pulses exactly once, 1 cycle after the 32nd write, then state_out=0.
- Emit stalls: highlight_empty=1 at index 10 for 4 cycles, then out_full=1 at index 25 for 3 cycles → no writes and no pops during either stall. Output sequence is identical to the emit scenario.
- Reset mid-EMIT at index 15 → state_out=0 and x=y=0 next cycle. No out_wr_en or frame_done is asserted afterwards until a new ingest and hough_done complete.
